des_rx_packer: RTL

Byte-serial front end for the 16-round DES decrypt datapath. Accepts a stream of tagged bytes over a valid/ready handshake and assembles 7 key bytes into the 56-bit round-key input. It packs ciphertext bytes into 64-bit blocks and presents each completed block, with its key, to the decrypt core through a registered valid/ready output slot. Sits directly upstream of the decrypt core; `blk_data`/`blk_key` wire straight to its `in`/`key` ports.

---
 rtl/des_rx_packer.sv | 110 +++++++++++
 1 files changed

// File: rtl/des_rx_packer.sv
// Byte-serial front end for the DES decrypt core: gathers a 56-bit key and
// 64-bit ciphertext blocks from a tagged byte stream into a registered output slot.
module des_rx_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_key,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [63:0] blk_data,
  output logic [55:0] blk_key,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        key_valid,
  output logic        err,
  output logic [15:0] blk_count
);

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned KEY_W     = 56;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned KEY_LAST  = 6;
  localparam int unsigned DATA_LAST = 7;

  logic [KEY_W-1:0] kreg;
  logic [KEY_W-1:0] freg;
  logic [CNT_W-1:0] kcnt;
  logic [CNT_W-1:0] dcnt;

  logic key_acc;
  logic data_acc;
  logic data_ok;
  logic last_byte;
  logic handoff;

  assign blk_key = kreg;

  // Key bytes only enter between blocks with an empty slot, so blk_key never
  // changes under a pending or partially filled block.
  always_comb begin
    s_ready = 1'b1;
    if (s_key) begin
      s_ready = !blk_valid && (dcnt == CNT_W'(0));
    end else if (dcnt == CNT_W'(DATA_LAST)) begin
      s_ready = !blk_valid || blk_ready;
    end
  end

  always_comb begin
    key_acc   = s_valid && s_ready && s_key;
    data_acc  = s_valid && s_ready && !s_key;
    data_ok   = data_acc && key_valid;
    last_byte = data_ok && (dcnt == CNT_W'(DATA_LAST));
    handoff   = blk_valid && blk_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kreg      <= '0;
      freg      <= '0;
      kcnt      <= '0;
      dcnt      <= '0;
      blk_data  <= '0;
      blk_valid <= 1'b0;
      key_valid <= 1'b0;
      err       <= 1'b0;
      blk_count <= '0;
    end else begin
      if (key_acc) begin
        kreg <= {kreg[KEY_W-BYTE_W-1:0], s_data};
        if (kcnt == CNT_W'(KEY_LAST)) begin
          kcnt      <= '0;
          key_valid <= 1'b1;
        end else begin
          kcnt <= kcnt + CNT_W'(1);
          if (kcnt == CNT_W'(0)) begin
            key_valid <= 1'b0;
          end
        end
      end

      // Data without a complete key is dropped and flagged.
      if (data_acc && !key_valid) begin
        err <= 1'b1;
      end

      if (data_ok) begin
        if (dcnt == CNT_W'(DATA_LAST)) begin
          blk_data <= {freg, s_data};
          dcnt     <= '0;
        end else begin
          freg <= {freg[KEY_W-BYTE_W-1:0], s_data};
          dcnt <= dcnt + CNT_W'(1);
        end
      end

      // A reload in the handoff cycle keeps the slot full for back-to-back blocks.
      if (last_byte) begin
        blk_valid <= 1'b1;
      end else if (handoff) begin
        blk_valid <= 1'b0;
      end

      if (handoff) begin
        blk_count <= blk_count + 16'(1);
      end
    end
  end

endmodule
